// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It covers the hazards
// that forwarding cannot resolve:
//   - load-use dependencies
//   - multi-cycle mul/div execution
//   - taken branches
//   - data-memory wait states
// It drives every pipeline-register enable and bubble control and keeps
// saturating performance counters.

module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_memRead,
    input  logic             ID_EX_isMulDiv,
    input  logic             md_done,
    input  logic             EX_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_flush,
    output logic             md_start,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              flush_inc;
    logic              load_use;

    // A load whose destination feeds the instruction in ID; x0 never creates a dependency.
    assign load_use = ID_EX_memRead && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    // Mealy decode of the pipeline controls and the next state. Reset forces every
    // register to hold and load a bubble, with no pulses.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        md_start     = 1'b0;
        mem_err      = 1'b0;
        state_next   = state;
        wait_next    = wait_cnt;
        flush_inc    = 1'b0;

        if (rst) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
            state_next   = RUN;
            wait_next    = '0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_write  = 1'b0;
                        EX_MEM_write = 1'b0;
                        MEM_WB_flush = 1'b1;
                        state_next   = MEM_WAIT;
                        wait_next    = '0;
                    end else if (ID_EX_isMulDiv) begin
                        md_start     = 1'b1;
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_write  = 1'b0;
                        EX_MEM_flush = 1'b1;
                        state_next   = MD_WAIT;
                    end else if (EX_branch_taken) begin
                        IF_ID_flush  = 1'b1;
                        ID_EX_flush  = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_flush  = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_next = RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_err    = 1'b1;
                        state_next = RUN;
                    end else begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_write  = 1'b0;
                        EX_MEM_write = 1'b0;
                        MEM_WB_flush = 1'b1;
                        wait_next    = wait_cnt + 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state_next = RUN;
                    end else begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_write  = 1'b0;
                        EX_MEM_flush = 1'b1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // State register and memory-wait cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Saturating performance counters: frozen-PC cycles and branch flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_inc && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed scenarios with literal expectations, then randomized traffic. A
// behavioural model counts frozen cycles and tracks whether a mul/div is
// outstanding; it is compared with the DUT on every falling edge.

module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Control vector order:
    // {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
    //  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, md_start, mem_err}
    localparam logic [9:0] DEF_V      = 10'b1111_0000_00;
    localparam logic [9:0] MEMSTALL_V = 10'b0000_0001_00;
    localparam logic [9:0] MDSTART_V  = 10'b0001_0010_10;
    localparam logic [9:0] MDWAIT_V   = 10'b0001_0010_00;
    localparam logic [9:0] BRANCH_V   = 10'b1111_1100_00;
    localparam logic [9:0] LOADUSE_V  = 10'b0011_0100_00;
    localparam logic [9:0] RESET_V    = 10'b0000_1111_00;
    localparam logic [9:0] TIMEOUT_V  = 10'b1111_0000_01;

    logic             clk;
    logic             rst;
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic [4:0]       ID_EX_rd;
    logic             ID_EX_memRead;
    logic             ID_EX_isMulDiv;
    logic             md_done;
    logic             EX_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             IF_ID_write;
    logic             ID_EX_write;
    logic             EX_MEM_write;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             EX_MEM_flush;
    logic             MEM_WB_flush;
    logic             md_start;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic [9:0]       ctrl;

    int check_count = 0;
    int pass_count  = 0;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .IF_ID_rs1      (IF_ID_rs1),
        .IF_ID_rs2      (IF_ID_rs2),
        .ID_EX_rd       (ID_EX_rd),
        .ID_EX_memRead  (ID_EX_memRead),
        .ID_EX_isMulDiv (ID_EX_isMulDiv),
        .md_done        (md_done),
        .EX_branch_taken(EX_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .ID_EX_write    (ID_EX_write),
        .EX_MEM_write   (EX_MEM_write),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_flush    (ID_EX_flush),
        .EX_MEM_flush   (EX_MEM_flush),
        .MEM_WB_flush   (MEM_WB_flush),
        .md_start       (md_start),
        .mem_err        (mem_err),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    assign ctrl = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                   IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
                   md_start, mem_err};

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic md, input logic mdd, input logic br,
                                 input logic rq, input logic rdy);
        @(posedge clk);
        #1;
        ID_EX_memRead   = mr;
        ID_EX_rd        = rd;
        IF_ID_rs1       = rs1;
        IF_ID_rs2       = rs2;
        ID_EX_isMulDiv  = md;
        md_done         = mdd;
        EX_branch_taken = br;
        dmem_req        = rq;
        dmem_ready      = rdy;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expectCtrl(input string name, input logic [9:0] v);
        @(negedge clk);
        checkOutput(name, 32'(ctrl), 32'(v));
    endtask

    // Behavioural reference. It tracks how many cycles the current memory wait has
    // been frozen and whether a mul/div is outstanding. Every falling edge it derives
    // the controls from the hazard rules and checks the DUT.
    bit m_in_md  = 1'b0;
    int m_frozen = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    always @(negedge clk) begin
        logic [9:0] exp_v;
        if (rst) begin
            m_in_md  = 1'b0;
            m_frozen = 0;
            m_stall  = 0;
            m_flush  = 0;
            checkOutput("model_ctrl_reset", 32'(ctrl), 32'(RESET_V));
            checkOutput("model_stall_reset", 32'(stall_cycles), 32'd0);
            checkOutput("model_flush_reset", 32'(flush_events), 32'd0);
        end else begin
            checkOutput("model_stall_cycles", 32'(stall_cycles), 32'(m_stall));
            checkOutput("model_flush_events", 32'(flush_events), 32'(m_flush));
            if (m_frozen > 0) begin
                if (dmem_ready) begin
                    exp_v    = DEF_V;
                    m_frozen = 0;
                end else if (m_frozen == MEM_TIMEOUT) begin
                    exp_v    = TIMEOUT_V;
                    m_frozen = 0;
                end else begin
                    exp_v    = MEMSTALL_V;
                    m_frozen = m_frozen + 1;
                end
            end else if (m_in_md) begin
                if (md_done) begin
                    exp_v   = DEF_V;
                    m_in_md = 1'b0;
                end else begin
                    exp_v = MDWAIT_V;
                end
            end else if (dmem_req && !dmem_ready) begin
                exp_v    = MEMSTALL_V;
                m_frozen = 1;
            end else if (ID_EX_isMulDiv) begin
                exp_v   = MDSTART_V;
                m_in_md = 1'b1;
            end else if (EX_branch_taken) begin
                exp_v = BRANCH_V;
                if (m_flush < CNT_MAX) m_flush = m_flush + 1;
            end else if (ID_EX_memRead && ID_EX_rd != 5'd0 &&
                         (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2)) begin
                exp_v = LOADUSE_V;
            end else begin
                exp_v = DEF_V;
            end
            if (!exp_v[9] && m_stall < CNT_MAX) m_stall = m_stall + 1;
            checkOutput("model_ctrl", 32'(ctrl), 32'(exp_v));
        end
    end

    // Directed scenarios with literal expectations, then random traffic.
    initial begin
        rst             = 1'b0;
        ID_EX_memRead   = 1'b0;
        ID_EX_rd        = 5'd0;
        IF_ID_rs1       = 5'd0;
        IF_ID_rs2       = 5'd0;
        ID_EX_isMulDiv  = 1'b0;
        md_done         = 1'b0;
        EX_branch_taken = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_ctrl", 32'(ctrl), 32'(RESET_V));
        checkOutput("reset_stall", 32'(stall_cycles), 32'd0);
        checkOutput("reset_flush", 32'(flush_events), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        expectCtrl("run_default", DEF_V);

        // Load-use: exactly one bubble cycle.
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectCtrl("load_use", LOADUSE_V);
        idleCycle();
        expectCtrl("after_load_use", DEF_V);
        checkOutput("stall_after_load_use", 32'(stall_cycles), 32'd1);
        // A load to x0 never creates a dependency.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectCtrl("load_x0", DEF_V);
        idleCycle();
        expectCtrl("after_load_x0", DEF_V);
        checkOutput("stall_after_load_x0", 32'(stall_cycles), 32'd1);

        // Mul/div with md_done four cycles after md_start.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expectCtrl("md_start", MDSTART_V);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            expectCtrl("md_wait", MDWAIT_V);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expectCtrl("md_release", DEF_V);
        idleCycle();
        expectCtrl("after_md", DEF_V);
        checkOutput("stall_after_md", 32'(stall_cycles), 32'd5);

        // Branch wins over a simultaneous load-use.
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expectCtrl("branch_over_load_use", BRANCH_V);
        idleCycle();
        expectCtrl("after_branch", DEF_V);
        checkOutput("stall_after_branch", 32'(stall_cycles), 32'd5);
        checkOutput("flush_after_branch", 32'(flush_events), 32'd1);

        // Memory wait released on the fourth cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            expectCtrl("mem_stall", MEMSTALL_V);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expectCtrl("mem_release", DEF_V);
        idleCycle();
        expectCtrl("after_mem", DEF_V);
        checkOutput("stall_after_mem", 32'(stall_cycles), 32'd8);

        // Memory timeout: sixteen frozen cycles, then forced release with mem_err.
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            expectCtrl("timeout_stall", MEMSTALL_V);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expectCtrl("timeout_release", TIMEOUT_V);
        idleCycle();
        expectCtrl("after_timeout", DEF_V);
        checkOutput("stall_after_timeout", 32'(stall_cycles), 32'd24);

        // md_done outside MD_WAIT has no effect.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expectCtrl("md_done_in_run", DEF_V);

        // Reset in the middle of a mul/div wait.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expectCtrl("md_start_2", MDSTART_V);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            expectCtrl("md_wait_2", MDWAIT_V);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midmd_reset_ctrl", 32'(ctrl), 32'(RESET_V));
        checkOutput("midmd_reset_stall", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        expectCtrl("after_reset_default", DEF_V);
        checkOutput("after_reset_stall", 32'(stall_cycles), 32'd0);
        checkOutput("after_reset_flush", 32'(flush_events), 32'd0);

        // Random traffic. The first stretch has no resets so the counters can saturate.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom % 2) == 0, 5'($urandom % 4), 5'($urandom % 4),
                          5'($urandom % 4), ($urandom % 6) == 0, ($urandom % 3) == 0,
                          ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0);
            rst = (i > 900) && (($urandom % 250) == 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It works alongside the combinational forwarding logic. It resolves the hazards forwarding cannot cover:
- load-use dependencies
- multi-cycle mul/div execution
- taken-branch squashing
- data-memory wait states

It drives the write-enable and flush (bubble) controls of every pipeline register and the PC, and keeps saturating performance counters.

## Interface
- MEM_TIMEOUT, 16: consecutive frozen cycles tolerated on a data-memory wait before forced release (≥2).
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- IF_ID_rs1, IF_ID_rs2  in  5 each  source registers of the instruction in ID.
- ID_EX_rd  in  5  destination of the instruction in EX.
- ID_EX_memRead  in  1  EX instruction is a load.
- ID_EX_isMulDiv  in  1  EX instruction needs the multi-cycle mul/div unit.
- md_done  in  1  mul/div result valid this cycle.
- EX_branch_taken  in  1  branch/jump in EX resolved taken.
- dmem_req, dmem_ready  in  1 each  MEM-stage access pending; memory completes it this cycle.
- pc_write, IF_ID_write, ID_EX_write, EX_MEM_write  out  1 each  register load enables.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load a NOP bubble.
- md_start  out  1  one-cycle launch pulse to mul/div unit.
- mem_err  out  1  one-cycle memory-timeout pulse.
- stall_cycles  out  CNT_W  cycles with pc_write=0.
- flush_events  out  CNT_W  branch flushes performed.

## Operation
- FSM states: RUN, MD_WAIT, MEM_WAIT.
- Internal registers: state, wait_cnt (clog2(MEM_TIMEOUT) bits), two counters.
- Control outputs are Mealy-decoded from state and inputs.
- Default (RUN, no hazard): all write enables 1, all flushes 0, pulses 0.
- RUN decision priority (first match wins):
  1. mem stall: dmem_req & !dmem_ready. pc/IF_ID/ID_EX/EX_MEM write=0, MEM_WB_flush=1. Go to MEM_WAIT, wait_cnt←0.
  2. mul/div entry: ID_EX_isMulDiv. md_start=1, pc/IF_ID/ID_EX write=0, EX_MEM_flush=1. Go to MD_WAIT.
  3. branch: EX_branch_taken. IF_ID_flush=1, ID_EX_flush=1, pc_write=1 (redirect). flush_events++.
  4. load-use: ID_EX_memRead & ID_EX_rd≠0 & (ID_EX_rd==IF_ID_rs1 | ID_EX_rd==IF_ID_rs2). pc_write=0, IF_ID_write=0, ID_EX_flush=1.
- MEM_WAIT behaviour:
  - dmem_ready=1: default outputs, go to RUN.
  - Else if wait_cnt==MEM_TIMEOUT-1: mem_err=1, default outputs (forced release), go to RUN.
  - Else: mem-stall outputs, wait_cnt++.
- MD_WAIT behaviour:
  - md_done=0: pc/IF_ID/ID_EX write=0, EX_MEM_flush=1.
  - md_done=1: default outputs, so EX/MEM captures the result. Go to RUN.
  - md_done is ignored outside MD_WAIT.
  - dmem_req is ignored in MD_WAIT: the MEM stage holds only bubbles.
- Branch and load-use are not evaluated in MD_WAIT/MEM_WAIT. They are re-evaluated in RUN because upstream registers are frozen.
- Counters saturate at all-ones and never wrap.
  - stall_cycles increments on every cycle with pc_write=0 while rst=0.
- Reset (rst=1, immediate, asynchronous):
  - state=RUN, wait_cnt=0, counters=0.
  - All write enables 0, all four flushes 1, md_start=0, mem_err=0.
  - Reset mid-MD_WAIT/MEM_WAIT abandons the operation. The mul/div unit shares rst.

## Timing
- All decisions are combinational in the cycle the hazard is visible. State updates on the next clk edge.
- Load-use: exactly 1 bubble cycle, then RUN with no residual state.
- Branch: 1 cycle; 2 younger instructions squashed.
- Mul/div with md_done asserted k cycles after md_start: frozen for k cycles (entry cycle plus k-1 MD_WAIT cycles), released in the md_done cycle.
- Memory wait released by dmem_ready in MEM_WAIT cycle n (wait_cnt=n-1): n frozen cycles (RUN cycle plus n-1 MEM_WAIT cycles), then release.
- Timeout: exactly MEM_TIMEOUT frozen cycles, then one release cycle with mem_err=1.
- dmem_ready in the RUN stall cycle itself means no stall.
- Simultaneous events resolve by RUN priority. A mem stall masks a concurrent mul/div, branch or load-use for that cycle.

## Test plan
- Load-use: ID_EX_memRead=1, ID_EX_rd=5, IF_ID_rs2=5 for one cycle -> pc_write=0, IF_ID_write=0, ID_EX_flush=1 for 1 cycle; stall_cycles=1. Repeat with ID_EX_rd=0 -> no stall.
- Mul/div: ID_EX_isMulDiv=1, md_done 4 cycles after md_start -> md_start pulse 1 cycle; pc_write=0 and EX_MEM_flush=1 for 4 cycles; all writes 1 in the md_done cycle; stall_cycles=4.
- Branch + load-use same cycle: EX_branch_taken=1 with load-use condition -> IF_ID_flush=ID_EX_flush=1, pc_write=1; flush_events=1; stall_cycles unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with MEM_WB_flush=1, release on the 4th, mem_err=0.
- Timeout: MEM_TIMEOUT=16, dmem_ready held 0 -> 16 frozen cycles, mem_err=1 on the 17th cycle with all writes 1, state RUN.
- Reset mid-MD_WAIT after 2 cycles -> outputs immediately go to the reset values; after deassert: RUN, counters 0, default outputs.
